// File: rtl/hit_resolver.sv
// Applies hit flags to player health, stun timers and knockback.
// Tracks KO state and declares the round winner.
module hit_resolver #(
  parameter int MAX_HEALTH   = 100,
  parameter int HEALTH_DEPTH = 7,
  parameter int KICK_DAMAGE  = 10,
  parameter int GRAB_DAMAGE  = 15,
  parameter int KICK_HITSTUN = 12,
  parameter int GRAB_HITSTUN = 20,
  parameter int BLOCKSTUN    = 6,
  parameter int STUN_DEPTH   = 5,
  parameter int STATE_DEPTH  = 3,
  parameter int BLOCK_CODE   = 3,
  parameter int KICK         = 1,
  parameter int GRAB         = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    new_round,
  input  logic [STATE_DEPTH-1:0]  p1_state,
  input  logic [STATE_DEPTH-1:0]  p2_state,
  input  logic                    p1_connects,
  input  logic                    p2_connects,
  output logic [HEALTH_DEPTH-1:0] p1_health,
  output logic [HEALTH_DEPTH-1:0] p2_health,
  output logic                    p1_stunned,
  output logic                    p2_stunned,
  output logic                    p1_knockback,
  output logic                    p2_knockback,
  output logic                    round_over,
  output logic [1:0]              winner
);

  typedef logic [HEALTH_DEPTH-1:0] health_t;
  typedef logic [STUN_DEPTH-1:0]   stun_t;
  typedef logic [STATE_DEPTH-1:0]  st_t;
  typedef enum logic {FIGHT, KO} fsm_t;

  localparam health_t H_MAX  = health_t'(MAX_HEALTH);
  localparam health_t D_KICK = health_t'(KICK_DAMAGE);
  localparam health_t D_GRAB = health_t'(GRAB_DAMAGE);
  localparam stun_t   S_KICK = stun_t'(KICK_HITSTUN);
  localparam stun_t   S_GRAB = stun_t'(GRAB_HITSTUN);
  localparam stun_t   S_BLK  = stun_t'(BLOCKSTUN);
  localparam st_t     C_KICK = st_t'(KICK);
  localparam st_t     C_GRAB = st_t'(GRAB);
  localparam st_t     C_BLK  = st_t'(BLOCK_CODE);

  fsm_t    state_q, state_n;
  health_t h1_q, h2_q, h1_n, h2_n;
  stun_t   s1_q, s2_q, s1_n, s2_n;
  logic    c1_d, c2_d;
  logic    kb1_n, kb2_n;
  logic    ro_n;
  logic [1:0] win_n;

  function automatic health_t sat_sub(health_t h, health_t d);
    return (h > d) ? h - d : '0;
  endfunction

  logic p1_hit, p2_hit;
  logic p1_kick, p2_kick;
  logic p1_grab, p2_grab;

  assign p1_hit = p1_connects & ~c1_d;
  assign p2_hit = p2_connects & ~c2_d;

  assign p1_kick = p1_hit & (p1_state == C_KICK);
  assign p2_kick = p2_hit & (p2_state == C_KICK);

  // a kick beats a grab launched on the same cycle
  assign p1_grab = p1_hit & (p1_state == C_GRAB) & ~p2_kick;
  assign p2_grab = p2_hit & (p2_state == C_GRAB) & ~p1_kick;

  always_comb begin
    state_n = state_q;
    h1_n    = h1_q;
    h2_n    = h2_q;
    s1_n    = s1_q;
    s2_n    = s2_q;
    kb1_n   = 1'b0;
    kb2_n   = 1'b0;
    ro_n    = round_over;
    win_n   = winner;

    if (frame_tick && s1_q != '0) s1_n = s1_q - 1'b1;
    if (frame_tick && s2_q != '0) s2_n = s2_q - 1'b1;

    if (new_round) begin
      state_n = FIGHT;
      h1_n    = H_MAX;
      h2_n    = H_MAX;
      s1_n    = '0;
      s2_n    = '0;
      ro_n    = 1'b0;
      win_n   = 2'b00;
    end else if (state_q == FIGHT) begin
      if ((p1_kick | p1_grab) && s2_q == '0) begin
        kb2_n = 1'b1;
        if (p1_grab) begin
          h2_n = sat_sub(h2_q, D_GRAB);
          s2_n = S_GRAB;
        end else if (p2_state == C_BLK) begin
          s2_n = S_BLK;
        end else begin
          h2_n = sat_sub(h2_q, D_KICK);
          s2_n = S_KICK;
        end
      end
      if ((p2_kick | p2_grab) && s1_q == '0) begin
        kb1_n = 1'b1;
        if (p2_grab) begin
          h1_n = sat_sub(h1_q, D_GRAB);
          s1_n = S_GRAB;
        end else if (p1_state == C_BLK) begin
          s1_n = S_BLK;
        end else begin
          h1_n = sat_sub(h1_q, D_KICK);
          s1_n = S_KICK;
        end
      end
      if (h1_n == '0 || h2_n == '0) begin
        state_n = KO;
        ro_n    = 1'b1;
        win_n   = {h1_n == '0, h2_n == '0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FIGHT;
      h1_q         <= H_MAX;
      h2_q         <= H_MAX;
      s1_q         <= '0;
      s2_q         <= '0;
      c1_d         <= 1'b0;
      c2_d         <= 1'b0;
      p1_knockback <= 1'b0;
      p2_knockback <= 1'b0;
      round_over   <= 1'b0;
      winner       <= 2'b00;
    end else begin
      state_q      <= state_n;
      h1_q         <= h1_n;
      h2_q         <= h2_n;
      s1_q         <= s1_n;
      s2_q         <= s2_n;
      c1_d         <= p1_connects;
      c2_d         <= p2_connects;
      p1_knockback <= kb1_n;
      p2_knockback <= kb2_n;
      round_over   <= ro_n;
      winner       <= win_n;
    end
  end

  assign p1_health  = h1_q;
  assign p2_health  = h2_q;
  assign p1_stunned = (s1_q != '0);
  assign p2_stunned = (s2_q != '0);

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: damage, block, trade,
// KO, draw, restart and reset behaviour.
module tb_hit_resolver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       new_round = 1'b0;
  logic [2:0] p1_state = 3'd0;
  logic [2:0] p2_state = 3'd0;
  logic       p1_connects = 1'b0;
  logic       p2_connects = 1'b0;
  logic [6:0] p1_health, p2_health;
  logic       p1_stunned, p2_stunned;
  logic       p1_knockback, p2_knockback;
  logic       round_over;
  logic [1:0] winner;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] KICK = 3'd1;
  localparam logic [2:0] GRAB = 3'd2;
  localparam logic [2:0] BLK  = 3'd3;

  hit_resolver dut (
    .clk(clk), .reset(reset),
    .frame_tick(frame_tick), .new_round(new_round),
    .p1_state(p1_state), .p2_state(p2_state),
    .p1_connects(p1_connects), .p2_connects(p2_connects),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_stunned(p1_stunned), .p2_stunned(p2_stunned),
    .p1_knockback(p1_knockback), .p2_knockback(p2_knockback),
    .round_over(round_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
  endtask

  task automatic restart();
    p1_connects = 1'b0;
    p2_connects = 1'b0;
    p1_state = IDLE;
    p2_state = IDLE;
    new_round = 1'b1;
    step();
    new_round = 1'b0;
    step();
  endtask

  task automatic do_hit(input logic a1, input logic a2);
    p1_connects = a1;
    p2_connects = a2;
    step();
    p1_connects = 1'b0;
    p2_connects = 1'b0;
    step();
    drain(25);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    n_cmp++;
    if ({p1_health, p2_health} !== {7'd100, 7'd100}) begin
      n_bad++;
      $display("FAIL rst_health: got %0d/%0d want 100/100",
               p1_health, p2_health);
    end
    n_cmp++;
    if ({p1_stunned, p2_stunned, p1_knockback, p2_knockback,
         round_over, winner} !== 7'b0) begin
      n_bad++;
      $display("FAIL rst_flags: got %b%b%b%b%b%b want 0000000",
               p1_stunned, p2_stunned, p1_knockback,
               p2_knockback, round_over, winner);
    end
  endtask

  task automatic test_kick();
    int kb_cnt;
    kb_cnt = 0;
    p1_state = KICK;
    p1_connects = 1'b1;
    step();
    n_cmp++;
    if (p2_health !== 7'd90 || p2_knockback !== 1'b1 ||
        p2_stunned !== 1'b1 || p1_health !== 7'd100) begin
      n_bad++;
      $display("FAIL kick_hit: got h2=%0d kb=%b st=%b h1=%0d want 90 1 1 100",
               p2_health, p2_knockback, p2_stunned, p1_health);
    end
    kb_cnt += int'(p2_knockback);
    repeat (2) begin
      step();
      kb_cnt += int'(p2_knockback);
    end
    n_cmp++;
    if (kb_cnt !== 1) begin
      n_bad++;
      $display("FAIL kick_kb_width: got %0d pulses want 1", kb_cnt);
    end
    p1_connects = 1'b0;
    step();
    p1_connects = 1'b1;
    step();
    n_cmp++;
    if (p2_health !== 7'd90 || p2_knockback !== 1'b0) begin
      n_bad++;
      $display("FAIL kick_in_stun: got h2=%0d kb=%b want 90 0",
               p2_health, p2_knockback);
    end
    p1_connects = 1'b0;
    drain(11);
    n_cmp++;
    if (p2_stunned !== 1'b1) begin
      n_bad++;
      $display("FAIL kick_stun11: got %b want 1", p2_stunned);
    end
    drain(1);
    n_cmp++;
    if (p2_stunned !== 1'b0) begin
      n_bad++;
      $display("FAIL kick_stun12: got %b want 0", p2_stunned);
    end
  endtask

  task automatic test_block_grab();
    restart();
    p1_state = KICK;
    p2_state = BLK;
    p1_connects = 1'b1;
    step();
    n_cmp++;
    if (p2_health !== 7'd100 || p2_knockback !== 1'b1 ||
        p2_stunned !== 1'b1) begin
      n_bad++;
      $display("FAIL block_hit: got h2=%0d kb=%b st=%b want 100 1 1",
               p2_health, p2_knockback, p2_stunned);
    end
    p1_connects = 1'b0;
    drain(5);
    n_cmp++;
    if (p2_stunned !== 1'b1) begin
      n_bad++;
      $display("FAIL block_stun5: got %b want 1", p2_stunned);
    end
    drain(1);
    n_cmp++;
    if (p2_stunned !== 1'b0) begin
      n_bad++;
      $display("FAIL block_stun6: got %b want 0", p2_stunned);
    end
    p1_state = GRAB;
    p1_connects = 1'b1;
    step();
    p1_connects = 1'b0;
    n_cmp++;
    if (p2_health !== 7'd85 || p2_knockback !== 1'b1) begin
      n_bad++;
      $display("FAIL grab_hit: got h2=%0d kb=%b want 85 1",
               p2_health, p2_knockback);
    end
    drain(19);
    n_cmp++;
    if (p2_stunned !== 1'b1) begin
      n_bad++;
      $display("FAIL grab_stun19: got %b want 1", p2_stunned);
    end
    drain(1);
    n_cmp++;
    if (p2_stunned !== 1'b0) begin
      n_bad++;
      $display("FAIL grab_stun20: got %b want 0", p2_stunned);
    end
  endtask

  task automatic test_simultaneous();
    restart();
    p1_state = KICK;
    p2_state = GRAB;
    p1_connects = 1'b1;
    p2_connects = 1'b1;
    step();
    n_cmp++;
    if (p2_health !== 7'd90 || p1_health !== 7'd100 ||
        p1_knockback !== 1'b0 || p2_knockback !== 1'b1) begin
      n_bad++;
      $display("FAIL kick_vs_grab: got h1=%0d h2=%0d kb1=%b kb2=%b want 100 90 0 1",
               p1_health, p2_health, p1_knockback, p2_knockback);
    end
    p1_connects = 1'b0;
    p2_connects = 1'b0;
    drain(13);
    p2_state = KICK;
    p1_connects = 1'b1;
    p2_connects = 1'b1;
    step();
    n_cmp++;
    if (p1_health !== 7'd90 || p2_health !== 7'd80 ||
        p1_knockback !== 1'b1 || p2_knockback !== 1'b1) begin
      n_bad++;
      $display("FAIL kick_trade: got h1=%0d h2=%0d kb1=%b kb2=%b want 90 80 1 1",
               p1_health, p2_health, p1_knockback, p2_knockback);
    end
    p1_connects = 1'b0;
    p2_connects = 1'b0;
    drain(13);
  endtask

  task automatic test_ko();
    restart();
    p1_state = GRAB;
    repeat (5) do_hit(1'b1, 1'b0);
    p1_state = KICK;
    repeat (2) do_hit(1'b1, 1'b0);
    n_cmp++;
    if (p2_health !== 7'd5 || round_over !== 1'b0) begin
      n_bad++;
      $display("FAIL ko_setup: got h2=%0d ro=%b want 5 0",
               p2_health, round_over);
    end
    p1_state = GRAB;
    p1_connects = 1'b1;
    step();
    p1_connects = 1'b0;
    n_cmp++;
    if (p2_health !== 7'd0 || round_over !== 1'b1 ||
        winner !== 2'b01) begin
      n_bad++;
      $display("FAIL ko_p1_wins: got h2=%0d ro=%b win=%b want 0 1 01",
               p2_health, round_over, winner);
    end
    drain(25);
    p1_state = KICK;
    p2_state = KICK;
    p1_connects = 1'b1;
    p2_connects = 1'b1;
    step();
    n_cmp++;
    if (p1_health !== 7'd100 || p2_health !== 7'd0 ||
        p1_knockback !== 1'b0 || p2_knockback !== 1'b0 ||
        round_over !== 1'b1 || winner !== 2'b01) begin
      n_bad++;
      $display("FAIL ko_frozen: got h1=%0d h2=%0d kb=%b%b ro=%b win=%b want 100 0 00 1 01",
               p1_health, p2_health, p1_knockback, p2_knockback,
               round_over, winner);
    end
    restart();
    n_cmp++;
    if (p1_health !== 7'd100 || p2_health !== 7'd100 ||
        round_over !== 1'b0 || winner !== 2'b00) begin
      n_bad++;
      $display("FAIL ko_restart: got h1=%0d h2=%0d ro=%b win=%b want 100 100 0 00",
               p1_health, p2_health, round_over, winner);
    end
  endtask

  task automatic test_draw();
    restart();
    p1_state = KICK;
    p2_state = KICK;
    repeat (9) do_hit(1'b1, 1'b1);
    n_cmp++;
    if (p1_health !== 7'd10 || p2_health !== 7'd10) begin
      n_bad++;
      $display("FAIL draw_setup: got %0d/%0d want 10/10",
               p1_health, p2_health);
    end
    p1_connects = 1'b1;
    p2_connects = 1'b1;
    step();
    p1_connects = 1'b0;
    p2_connects = 1'b0;
    n_cmp++;
    if (p1_health !== 7'd0 || p2_health !== 7'd0 ||
        round_over !== 1'b1 || winner !== 2'b11) begin
      n_bad++;
      $display("FAIL draw_ko: got h1=%0d h2=%0d ro=%b win=%b want 0 0 1 11",
               p1_health, p2_health, round_over, winner);
    end
    drain(13);
    // restart and a fresh hit on the same edge: restart wins
    p1_connects = 1'b1;
    new_round = 1'b1;
    step();
    new_round = 1'b0;
    n_cmp++;
    if (p2_health !== 7'd100 || p2_knockback !== 1'b0 ||
        p2_stunned !== 1'b0 || round_over !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_vs_hit: got h2=%0d kb=%b st=%b ro=%b want 100 0 0 0",
               p2_health, p2_knockback, p2_stunned, round_over);
    end
    step();
    n_cmp++;
    if (p2_health !== 7'd100 || p2_knockback !== 1'b0) begin
      n_bad++;
      $display("FAIL held_level: got h2=%0d kb=%b want 100 0",
               p2_health, p2_knockback);
    end
    p1_connects = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_stun();
    restart();
    p1_state = GRAB;
    do_hit(1'b1, 1'b0);
    p1_connects = 1'b1;
    step();
    p1_connects = 1'b0;
    drain(3);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
    n_cmp++;
    if (p2_health !== 7'd70 || p2_stunned !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_reset: got h2=%0d st=%b want 70 1",
               p2_health, p2_stunned);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_cmp++;
    if (p2_health !== 7'd100 || p2_stunned !== 1'b0 ||
        p1_knockback !== 1'b0 || p2_knockback !== 1'b0 ||
        round_over !== 1'b0 || winner !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_stun_reset: got h2=%0d st=%b kb=%b%b ro=%b win=%b want 100 0 00 0 00",
               p2_health, p2_stunned, p1_knockback, p2_knockback,
               round_over, winner);
    end
  endtask

  initial begin
    test_reset();
    test_kick();
    test_block_grab();
    test_simultaneous();
    test_ko();
    test_draw();
    test_reset_mid_stun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
